// File: rtl/uart_debug_ctrl.sv
// Host command sequencer between the UART word interfaces and the MIPS pipeline: program load, run, step, dump.
// Optional byte/word watchdog is enabled with the DBG_TIMEOUT_EN macro.
module uart_debug_ctrl #(
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned DUMP_WORDS     = 40,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_done,
  input  logic [7:0]        rx_data,
  input  logic              mips_halt,
  input  logic [31:0]       dbg_data,
  input  logic              tx_word_done,
  output logic              mips_enable,
  output logic              prog_we,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [31:0]       prog_data,
  output logic [7:0]        dbg_sel,
  output logic [31:0]       tx_word,
  output logic              tx_start,
  output logic [31:0]       cycle_count,
  output logic              busy,
  output logic              err
);

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_DUMP = 8'h44;
  localparam logic [7:0] LAST_IDX = 8'(DUMP_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_CNT, LOAD_DATA, RUN, STEP, DUMP_SEL, DUMP_SEND, DUMP_WAIT
  } state_t;

  state_t      state;
  logic [1:0]  byte_cnt;
  logic [31:0] shift_q;
  logic [31:0] words_left;
  logic [31:0] next_word;

  assign next_word   = {shift_q[23:0], rx_data};
  assign busy        = (state != IDLE);
  // Halt gates the enable in the same cycle it is seen
  assign mips_enable = (state == STEP) || ((state == RUN) && !mips_halt);

`ifdef DBG_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] tmo_cnt;
  logic        err_q;
  logic        tmo_watch;
  logic        tmo_restart;
  logic        cmd_valid;

  assign tmo_watch   = (state == LOAD_CNT) || (state == LOAD_DATA) || (state == DUMP_WAIT);
  assign tmo_restart = (state == DUMP_WAIT) ? tx_word_done : rx_done;
  assign cmd_valid   = (rx_data == CMD_LOAD) || (rx_data == CMD_RUN) ||
                       (rx_data == CMD_STEP) || (rx_data == CMD_DUMP);
  assign err         = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      byte_cnt    <= 2'd0;
      shift_q     <= 32'd0;
      words_left  <= 32'd0;
      prog_we     <= 1'b0;
      prog_addr   <= '0;
      prog_data   <= 32'd0;
      dbg_sel     <= 8'd0;
      tx_word     <= 32'd0;
      tx_start    <= 1'b0;
      cycle_count <= 32'd0;
`ifdef DBG_TIMEOUT_EN
      tmo_cnt     <= 32'd0;
      err_q       <= 1'b0;
`endif
    end else begin
      prog_we  <= 1'b0;
      tx_start <= 1'b0;
      // Address advances on the cycle after each write pulse
      if (prog_we) prog_addr <= prog_addr + ADDR_W'(1);

      case (state)
        IDLE: begin
          if (rx_done) begin
            case (rx_data)
              CMD_LOAD: begin state <= LOAD_CNT; byte_cnt <= 2'd0; end
              CMD_RUN:  begin state <= RUN;  cycle_count <= 32'd0; end
              CMD_STEP: begin state <= STEP; cycle_count <= 32'd0; end
              CMD_DUMP: begin state <= DUMP_SEL; dbg_sel <= 8'd0; end
              default:  ;
            endcase
          end
        end
        LOAD_CNT: begin
          if (rx_done) begin
            shift_q  <= next_word;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              words_left <= next_word;
              prog_addr  <= '0;
              state      <= (next_word == 32'd0) ? IDLE : LOAD_DATA;
            end
          end
        end
        LOAD_DATA: begin
          if (rx_done) begin
            shift_q  <= next_word;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              prog_data  <= next_word;
              prog_we    <= 1'b1;
              words_left <= words_left - 32'd1;
              if (words_left == 32'd1) state <= IDLE;
            end
          end
        end
        RUN: begin
          if (mips_halt) begin
            state   <= DUMP_SEL;
            dbg_sel <= 8'd0;
          end else if (cycle_count != 32'hFFFF_FFFF) begin
            cycle_count <= cycle_count + 32'd1;
          end
        end
        STEP: begin
          cycle_count <= 32'd1;
          dbg_sel     <= 8'd0;
          state       <= DUMP_SEL;
        end
        DUMP_SEL: state <= DUMP_SEND;
        DUMP_SEND: begin
          tx_word  <= (dbg_sel == 8'd0) ? cycle_count : dbg_data;
          tx_start <= 1'b1;
          state    <= DUMP_WAIT;
        end
        DUMP_WAIT: begin
          if (tx_word_done) begin
            dbg_sel <= dbg_sel + 8'd1;
            state   <= (dbg_sel == LAST_IDX) ? IDLE : DUMP_SEL;
          end
        end
        default: state <= IDLE;
      endcase

`ifdef DBG_TIMEOUT_EN
      // Watchdog: abandon the transfer when the host or transmitter stalls
      if (!tmo_watch || tmo_restart) begin
        tmo_cnt <= 32'd0;
      end else if (tmo_cnt == TMO_LAST) begin
        tmo_cnt <= 32'd0;
        err_q   <= 1'b1;
        state   <= IDLE;
      end else begin
        tmo_cnt <= tmo_cnt + 32'd1;
      end
      if ((state == IDLE) && rx_done && cmd_valid) err_q <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_uart_debug_ctrl.sv
// Self-checking bench for uart_debug_ctrl: command decode table plus load/step/run/dump/reset sequences.
module tb_uart_debug_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_done;
  logic [7:0]  rx_data;
  logic        mips_halt;
  logic [31:0] dbg_data;
  logic        tx_word_done;
  logic        mips_enable;
  logic        prog_we;
  logic [9:0]  prog_addr;
  logic [31:0] prog_data;
  logic [7:0]  dbg_sel;
  logic [31:0] tx_word;
  logic        tx_start;
  logic [31:0] cycle_count;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  uart_debug_ctrl #(.ADDR_W(10), .DUMP_WORDS(4), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset), .rx_done(rx_done), .rx_data(rx_data),
    .mips_halt(mips_halt), .dbg_data(dbg_data), .tx_word_done(tx_word_done),
    .mips_enable(mips_enable), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .dbg_sel(dbg_sel), .tx_word(tx_word), .tx_start(tx_start),
    .cycle_count(cycle_count), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  assign dbg_data = 32'h100 + 32'(dbg_sel);

  // Activity log sampled mid-cycle
  logic [9:0]  we_addr[$];
  logic [31:0] we_data[$];
  logic [31:0] tx_log[$];
  int          en_cycles = 0;

  always @(negedge clk) begin
    if (prog_we) begin
      we_addr.push_back(prog_addr);
      we_data.push_back(prog_data);
    end
    if (tx_start) tx_log.push_back(tx_word);
    if (mips_enable) en_cycles++;
  end

  // Transmitter model: word completes 20 cycles after its start strobe
  int pend = 0;
  always @(negedge clk) begin
    tx_word_done = 1'b0;
    if (reset !== 1'b1) begin
      pend = 0;
    end else if (tx_start) begin
      pend = 20;
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) tx_word_done = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    step();
    rx_done = 1'b0;
    step();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    step();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic       halt;
    logic       exp_busy;
    logic       exp_en;
  } dec_vec_t;

  dec_vec_t vecs[8];
  logic [7:0] load_bytes[13];
  int b0, t0, e0;

  initial begin
    vecs[0] = '{8'h4C, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'h52, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{8'h52, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'h53, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{8'h44, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'h99, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'h6C, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{8'h00, 1'b0, 1'b0, 1'b0};
    load_bytes = '{8'h4C, 8'h00, 8'h00, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                   8'hAA, 8'hBB, 8'hCC, 8'hDD};

    reset = 1'b0; rx_done = 1'b0; rx_data = 8'h00; mips_halt = 1'b0;

    // Reset values, sampled while reset is still asserted
    repeat (2) step();
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_enable", 32'(mips_enable), 32'd0);
    chk("rst_prog_we", 32'(prog_we), 32'd0);
    chk("rst_prog_addr", 32'(prog_addr), 32'd0);
    chk("rst_prog_data", prog_data, 32'd0);
    chk("rst_dbg_sel", 32'(dbg_sel), 32'd0);
    chk("rst_tx_word", tx_word, 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_cycle_count", cycle_count, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    step();
    reset = 1'b1;
    step();

    // Command decode table: state one cycle after the byte
    foreach (vecs[i]) begin
      do_reset();
      mips_halt = vecs[i].halt;
      rx_data = vecs[i].cmd;
      rx_done = 1'b1;
      step();
      rx_done = 1'b0;
      @(negedge clk);
      chk($sformatf("dec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      chk($sformatf("dec%0d_enable", i), 32'(mips_enable), 32'(vecs[i].exp_en));
      mips_halt = 1'b0;
    end

    // Load two words
    do_reset();
    b0 = we_addr.size();
    foreach (load_bytes[i]) send_byte(load_bytes[i]);
    repeat (2) step();
    chk("load_count", 32'(we_addr.size() - b0), 32'd2);
    chk("load_addr0", 32'(we_addr[b0]), 32'd0);
    chk("load_data0", we_data[b0], 32'h11223344);
    chk("load_addr1", 32'(we_addr[b0+1]), 32'd1);
    chk("load_data1", we_data[b0+1], 32'hAABBCCDD);
    chk("load_busy", 32'(busy), 32'd0);
    chk("load_next_addr", 32'(prog_addr), 32'd2);

    // Single step then dump
    do_reset();
    t0 = tx_log.size(); e0 = en_cycles;
    send_byte(8'h53);
    wait_idle("step_idle");
    chk("step_en_cycles", 32'(en_cycles - e0), 32'd1);
    chk("step_cycle_count", cycle_count, 32'd1);
    chk("step_tx_count", 32'(tx_log.size() - t0), 32'd4);
    chk("step_tx0", tx_log[t0], 32'h00000001);
    chk("step_tx1", tx_log[t0+1], 32'h00000101);
    chk("step_tx2", tx_log[t0+2], 32'h00000102);
    chk("step_tx3", tx_log[t0+3], 32'h00000103);

    // Run until halt 50 cycles after enable; stray bytes ignored
    do_reset();
    t0 = tx_log.size(); e0 = en_cycles; b0 = we_addr.size();
    rx_data = 8'h52;
    rx_done = 1'b1;
    step();
    for (int i = 0; i < 50; i++) begin
      rx_done = (i == 10) || (i == 20);
      rx_data = (i == 10) ? 8'h4C : 8'h53;
      step();
    end
    rx_done = 1'b0;
    chk("run_enable_before_halt", 32'(mips_enable), 32'd1);
    mips_halt = 1'b1;
    #1;
    chk("run_enable_gated", 32'(mips_enable), 32'd0);
    wait_idle("run_idle");
    mips_halt = 1'b0;
    chk("run_en_cycles", 32'(en_cycles - e0), 32'd50);
    chk("run_cycle_count", cycle_count, 32'd50);
    chk("run_tx_count", 32'(tx_log.size() - t0), 32'd4);
    chk("run_tx0", tx_log[t0], 32'h00000032);
    chk("run_no_writes", 32'(we_addr.size() - b0), 32'd0);

    // Dump with an unknown byte during the dump
    do_reset();
    t0 = tx_log.size(); e0 = en_cycles; b0 = we_addr.size();
    send_byte(8'h44);
    send_byte(8'h99);
    wait_idle("dump_idle");
    chk("dump_tx_count", 32'(tx_log.size() - t0), 32'd4);
    chk("dump_tx0", tx_log[t0], 32'h00000000);
    chk("dump_tx3", tx_log[t0+3], 32'h00000103);
    chk("dump_no_enable", 32'(en_cycles - e0), 32'd0);
    chk("dump_no_writes", 32'(we_addr.size() - b0), 32'd0);

    // Reset in the middle of a data word abandons the load
    do_reset();
    b0 = we_addr.size();
    send_byte(8'h4C); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'hAA); send_byte(8'hBB);
    do_reset();
    chk("mid_rst_busy", 32'(busy), 32'd0);
    send_byte(8'h4C); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    repeat (2) step();
    chk("mid_rst_count", 32'(we_addr.size() - b0), 32'd1);
    chk("mid_rst_addr", 32'(we_addr[b0]), 32'd0);
    chk("mid_rst_data", we_data[b0], 32'h01020304);
    chk("mid_rst_idle", 32'(busy), 32'd0);

`ifdef DBG_TIMEOUT_EN
    // Watchdog: stalled load count aborts with err, next command clears it
    do_reset();
    send_byte(8'h4C);
    send_byte(8'h00);
    wait_idle("tmo_idle");
    chk("tmo_err_set", 32'(err), 32'd1);
    send_byte(8'h44);
    chk("tmo_err_clear", 32'(err), 32'd0);
`else
    chk("err_tied_low", 32'(err), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, checks %0d", checks);
    $fatal(1, "timeout");
  end

endmodule
